// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_div_pkg                                                  |
// | Description : Shared width defaults and reset-ratio helper for the divider |
// |               bank.                                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package clk_div_pkg;

    localparam int CNT_W_DEF = 16;

    typedef logic [CNT_W_DEF-1:0] div_t;

    // Reset ratio of channel idx: ch0=/2, ch1=/4, ... ch9=/20.
    function automatic int unsigned def_div(input int unsigned idx);
        return 2 * (idx + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_div_ch                                                   |
// | Description : One divide-by-N channel with shadowed ratio applied only at  |
// |               period boundaries.                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int          CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sync,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_cout,
    output logic             o_pend
);

    localparam logic [CNT_W-1:0] c_def = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_two = CNT_W'(2);

    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cout;
    logic             r_pend;

    logic             w_enabled;
    logic             w_apply;
    logic             w_high;

    // A disabled channel sits permanently at a period boundary.
    assign w_enabled = (r_div_act >= c_two);
    assign w_apply   = !w_enabled || (r_cnt == (r_div_act - c_one));
    assign w_high    = w_enabled && (r_cnt < (r_div_act >> 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= c_def;
            r_div_act <= c_def;
            r_cnt     <= '0;
            r_cout    <= 1'b0;
            r_pend    <= 1'b0;
        end else if (i_sync) begin
            if (r_pend) begin
                r_div_act <= r_shadow;
            end
            r_cnt  <= '0;
            r_cout <= 1'b0;
            if (i_we) begin
                r_shadow <= i_div;
                r_pend   <= 1'b1;
            end else begin
                r_pend   <= 1'b0;
            end
        end else begin
            r_cout <= w_high;
            if (w_apply) begin
                r_cnt  <= '0;
                r_pend <= 1'b0;
                // A write landing on the boundary bypasses the shadow wait.
                if (i_we) begin
                    r_shadow  <= i_div;
                    r_div_act <= i_div;
                end else if (r_pend) begin
                    r_div_act <= r_shadow;
                end
            end else begin
                r_cnt <= r_cnt + c_one;
                if (i_we) begin
                    r_shadow <= i_div;
                    r_pend   <= 1'b1;
                end
            end
        end
    end

    assign o_cout = r_cout;
    assign o_pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_div_bank                                                 |
// | Description : NUM_CH glitch-free programmable clock dividers. Define       |
// |               CLK_DIV_BANK_SYNC_EN to add the sync_i phase-align strobe.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int NUM_CH = 10,
    parameter  int CNT_W  = CNT_W_DEF,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic              sync_i,
`endif
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] cout,
    output logic [NUM_CH-1:0] pend
);

    logic              w_sync;
    logic [NUM_CH-1:0] w_we;

`ifdef CLK_DIV_BANK_SYNC_EN
    assign w_sync = sync_i;
`else
    assign w_sync = 1'b0;
`endif

    // Out-of-range cfg_ch matches no channel, so such writes vanish.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_we[g] = cfg_we && (cfg_ch == CH_W'(g));

        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (def_div(g))
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_sync (w_sync),
            .i_we   (w_we[g]),
            .i_div  (cfg_div),
            .o_cout (cout[g]),
            .o_pend (pend[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clk_div_bank                                              |
// | Description : Self-checking bench for clk_div_bank with waveform model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_clk_div_bank;

    localparam int NCH = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync_i = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ch = '0;
    logic [15:0] cfg_div = '0;
    logic [NCH-1:0] cout;
    logic [NCH-1:0] pend;

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    clk_div_bank dut (
        .clk     (clk),
        .rst     (rst),
`ifdef CLK_DIV_BANK_SYNC_EN
        .sync_i  (sync_i),
`endif
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cout    (cout),
        .pend    (pend)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each channel replays a queue holding one whole period of output bits.
    // An empty queue after a pop marks the period boundary where new ratios take hold.
    int m_n   [NCH];
    int m_sh  [NCH];
    bit m_pend[NCH];
    bit m_out [NCH];
    bit wave  [NCH][$];
    bit m_hit;
    logic [NCH-1:0] m_cv;
    logic [NCH-1:0] m_pv;

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                m_n[i] = 2 * (i + 1);
                m_sh[i] = m_n[i];
                m_pend[i] = 1'b0;
                m_out[i] = 1'b0;
                wave[i].delete();
            end else begin
                m_hit = cfg_we && (int'(cfg_ch) == i);
                if (sync_i) begin
                    if (m_pend[i]) m_n[i] = m_sh[i];
                    wave[i].delete();
                    m_out[i] = 1'b0;
                    m_pend[i] = m_hit;
                    if (m_hit) m_sh[i] = int'(cfg_div);
                end else begin
                    if (wave[i].size() == 0) begin
                        if (m_n[i] >= 2) begin
                            for (int k = 0; k < m_n[i]; k++) wave[i].push_back(k < m_n[i] / 2);
                        end else begin
                            wave[i].push_back(1'b0);
                        end
                    end
                    m_out[i] = wave[i].pop_front();
                    if (wave[i].size() == 0) begin
                        if (m_hit) begin
                            m_n[i] = int'(cfg_div);
                            m_sh[i] = int'(cfg_div);
                        end else if (m_pend[i]) begin
                            m_n[i] = m_sh[i];
                        end
                        m_pend[i] = 1'b0;
                    end else if (m_hit) begin
                        m_sh[i] = int'(cfg_div);
                        m_pend[i] = 1'b1;
                    end
                end
            end
            m_cv[i] = m_out[i];
            m_pv[i] = m_pend[i];
        end
        #1;
        if (chk_en) begin
            check("model_cout", 32'(cout), 32'(m_cv));
            check("model_pend", 32'(pend), 32'(m_pv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int ch, input int div);
        cfg_we = 1'b1;
        cfg_ch = 4'(ch);
        cfg_div = 16'(div);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_pend_clear(input int ch, input string nm);
        int k;
        k = 0;
        while (pend[ch] && k < 400) begin
            tick();
            k++;
        end
        if (pend[ch]) check(nm, 32'(pend[ch]), 32'd0);
    endtask

    task automatic measure(input int ch, output int per, output int hi);
        logic prev;
        bit   found;
        int   k;
        per = -1;
        hi = 0;
        found = 1'b0;
        prev = cout[ch];
        k = 0;
        while (!found && k < 200) begin
            tick();
            k++;
            if (cout[ch] && !prev) found = 1'b1;
            prev = cout[ch];
        end
        if (found) begin
            per = 1;
            hi = 1;
            k = 0;
            found = 1'b0;
            while (!found && k < 200) begin
                tick();
                k++;
                if (cout[ch] && !prev) begin
                    found = 1'b1;
                end else begin
                    per++;
                    if (cout[ch]) hi++;
                end
                prev = cout[ch];
            end
            if (!found) per = -1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    typedef struct {
        int ch;
        int div;
        int exp_per;
        int exp_high;
    } vec_t;

    vec_t tbl[9];
    int   per, hi, k;

    initial begin
        tbl[0] = '{3, 7, 7, 3};
        tbl[1] = '{0, 3, 3, 1};
        tbl[2] = '{5, 2, 2, 1};
        tbl[3] = '{7, 11, 11, 5};
        tbl[4] = '{9, 4, 4, 2};
        tbl[5] = '{2, 0, 0, 0};
        tbl[6] = '{2, 5, 5, 2};
        tbl[7] = '{4, 16, 16, 8};
        tbl[8] = '{6, 13, 13, 6};

        // Reset state and defaults
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        rst = 1'b0;
        tick();
        check("first_edge_cout", 32'(cout), 32'h3FF);
        measure(0, per, hi); check("ch0_per", 32'(per), 32'd2);  check("ch0_high", 32'(hi), 32'd1);
        measure(1, per, hi); check("ch1_per", 32'(per), 32'd4);  check("ch1_high", 32'(hi), 32'd2);
        measure(9, per, hi); check("ch9_per", 32'(per), 32'd20); check("ch9_high", 32'(hi), 32'd10);

        // ch3 rewritten mid-period: old /8 period runs out (5 more edges) before /7
        do_reset();
        tick();
        tick();
        wr(3, 7);
        check("ch3_pend_set", 32'(pend[3]), 32'd1);
        k = 0;
        while (pend[3] && k < 50) begin
            tick();
            k++;
        end
        check("ch3_pend_len", 32'(k), 32'd5);
        measure(3, per, hi); check("ch3_per", 32'(per), 32'd7); check("ch3_high", 32'(hi), 32'd3);

        // ch2 disabled via 1 then 0, then re-enabled with 5
        wr(2, 1);
        wr(2, 0);
        wait_pend_clear(2, "ch2_pend_timeout");
        hi = 0;
        repeat (24) begin
            tick();
            hi += int'(cout[2]);
        end
        check("ch2_disabled_high", 32'(hi), 32'd0);
        cfg_we = 1'b1; cfg_ch = 4'd2; cfg_div = 16'd5;
        tick();
        cfg_we = 1'b0;
        check("ch2_write_edge", 32'(cout[2]), 32'd0);
        tick();
        check("ch2_rise_after", 32'(cout[2]), 32'd1);

        // Back-to-back writes to ch0: only the last one applies
        wr(0, 20);
        wait_pend_clear(0, "ch0_pend_timeout");
        repeat (3) tick();
        wr(0, 9);
        wr(0, 3);
        check("ch0_pend_set", 32'(pend[0]), 32'd1);
        wait_pend_clear(0, "ch0_pend_timeout2");
        measure(0, per, hi); check("ch0_last_per", 32'(per), 32'd3); check("ch0_last_high", 32'(hi), 32'd1);
        wr(NCH, 7);
        check("bad_ch_pend", 32'(pend), 32'd0);

        // Write landing exactly on ch1's wrap (4th edge after reset release)
        do_reset();
        tick();
        tick();
        tick();
        wr(1, 6);
        check("ch1_wrap_pend", 32'(pend[1]), 32'd0);
        measure(1, per, hi); check("ch1_new_per", 32'(per), 32'd6); check("ch1_new_high", 32'(hi), 32'd3);

        // Reset mid-period discards pending writes and restores defaults
        wr(4, 3);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_pend", 32'(pend), 32'd0);
        rst = 1'b0;
        tick();
        check("midrst_first", 32'(cout), 32'h3FF);
        measure(1, per, hi); check("ch1_def_per", 32'(per), 32'd4);
        measure(4, per, hi); check("ch4_def_per", 32'(per), 32'd10);

        // Table-driven ratio programming
        for (int i = 0; i < 9; i++) begin
            wr(tbl[i].ch, tbl[i].div);
            wait_pend_clear(tbl[i].ch, $sformatf("tbl%0d_pend_timeout", i));
            if (tbl[i].exp_per == 0) begin
                per = 0;
                hi = 0;
                repeat (30) begin
                    tick();
                    hi += int'(cout[tbl[i].ch]);
                end
            end else begin
                measure(tbl[i].ch, per, hi);
            end
            check($sformatf("tbl%0d_per", i), 32'(per), 32'(tbl[i].exp_per));
            check($sformatf("tbl%0d_high", i), 32'(hi), 32'(tbl[i].exp_high));
        end

`ifdef CLK_DIV_BANK_SYNC_EN
        // Common phase after sync
        wr(0, 4);
        wr(1, 6);
        wait_pend_clear(0, "sync_pend0_timeout");
        wait_pend_clear(1, "sync_pend1_timeout");
        sync_i = 1'b1;
        tick();
        sync_i = 1'b0;
        check("sync_cout0", 32'(cout), 32'd0);
        tick();
        check("sync_rise", 32'(cout[1:0]), 32'd3);
        repeat (10) tick();
        tick();
        check("sync_p11", 32'(cout[1:0]), 32'd0);
        tick();
        check("sync_p12", 32'(cout[1:0]), 32'd3);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_ch = 4'($urandom_range(0, 11));
            cfg_div = 16'($urandom_range(0, 24));
`ifdef CLK_DIV_BANK_SYNC_EN
            sync_i = ($urandom_range(0, 59) == 0);
`endif
            tick();
        end
        rst = 1'b0;
        cfg_we = 1'b0;
        sync_i = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
